// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on device clock edges, ACK check.
// The open-drain enables are registered so that reset releases both lines asynchronously.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] send_data,
   input  logic       send_valid,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic [2:0] dbg_state
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_INHIBIT  = 3'd1;
   localparam logic [2:0] S_RTS      = 3'd2;
   localparam logic [2:0] S_SHIFT    = 3'd3;
   localparam logic [2:0] S_ACK_WAIT = 3'd4;
   localparam logic [2:0] S_RELEASE  = 3'd5;

   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic          r_ack;
   logic          r_done;
   logic          r_error;
   logic          r_clk_oe;
   logic          r_dat_oe;
   logic          r_clk_meta;
   logic          r_clk_sync;
   logic          r_clk_prev;
   logic          r_dat_meta;
   logic          r_dat_sync;

   logic          w_fall;
   logic          w_tmo_phase;
   logic          w_timeout;
   logic [3:0]    w_n;

   assign w_fall      = r_clk_prev & ~r_clk_sync;
   assign w_tmo_phase = (r_state == S_RTS) || (r_state == S_SHIFT) ||
                        (r_state == S_ACK_WAIT) || (r_state == S_RELEASE);
   assign w_timeout   = w_tmo_phase && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_n         = r_bit + 4'd1;

   assign busy       = (r_state != S_IDLE);
   assign done       = r_done;
   assign error      = r_error;
   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;
   assign dbg_state  = r_state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_ack      <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_clk_oe   <= 1'b0;
         r_dat_oe   <= 1'b0;
         r_clk_meta <= 1'b0;
         r_clk_sync <= 1'b0;
         r_clk_prev <= 1'b0;
         r_dat_meta <= 1'b0;
         r_dat_sync <= 1'b0;
      end else begin
         r_clk_meta <= ps2_clk_in;
         r_clk_sync <= r_clk_meta;
         r_clk_prev <= r_clk_sync;
         r_dat_meta <= ps2_dat_in;
         r_dat_sync <= r_dat_meta;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         if (w_tmo_phase) begin
            r_cnt <= r_cnt + 1'b1;
         end
         // A timeout wins over any falling edge seen in the same cycle.
         if (w_timeout) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (send_valid && !r_done && !r_error) begin
                     r_shift  <= send_data;
                     r_parity <= ~^send_data;
                     r_cnt    <= '0;
                     r_bit    <= '0;
                     r_clk_oe <= 1'b1;
                     r_dat_oe <= 1'b0;
                     r_state  <= S_INHIBIT;
                  end
               end
               S_INHIBIT: begin
                  // INHIBIT_CYCLES with clock alone held, then one cycle with the start bit too.
                  if (r_cnt == CW'(INHIBIT_CYCLES)) begin
                     r_clk_oe <= 1'b0;
                     r_cnt    <= '0;
                     r_state  <= S_RTS;
                  end else begin
                     if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                        r_dat_oe <= 1'b1;
                     end
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_RTS: begin
                  r_state <= S_SHIFT;
               end
               S_SHIFT: begin
                  if (w_fall) begin
                     r_bit <= w_n;
                     if (w_n <= 4'd8) begin
                        r_dat_oe <= ~r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                     end else if (w_n == 4'd9) begin
                        r_dat_oe <= ~r_parity;
                     end else begin
                        r_dat_oe <= 1'b0;
                        r_state  <= S_ACK_WAIT;
                     end
                  end
               end
               S_ACK_WAIT: begin
                  if (w_fall) begin
                     r_ack   <= ~r_dat_sync;
                     r_state <= S_RELEASE;
                  end
               end
               S_RELEASE: begin
                  if (r_clk_sync && r_dat_sync) begin
                     r_done  <= r_ack;
                     r_error <= ~r_ack;
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a keyboard model, response and frame scoreboards.
module tb_ps2_host_tx;

   localparam int INH  = 500;
   localparam int TMO  = 2000;
   localparam int HALF = 20;
   localparam int LIM  = INH + TMO + 1000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] send_data = 8'h00;
   logic       send_valid = 1'b0;
   logic       busy, done, error, clk_oe, dat_oe;
   logic [2:0] dbg_state;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   wire        ps2_clk_line = ~(clk_oe | dev_clk_low);
   wire        ps2_dat_line = ~(dat_oe | dev_dat_low);

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rel_cyc  = 0;
   int done_cyc = 0;
   int inh_cnt  = 0;
   logic prev_clk_oe = 1'b0;
   logic [2:0]  e_resp;
   logic [10:0] frame_q[$];
   logic [2:0]  exp_q[$];

   logic [7:0] v_data[4] = '{8'hED, 8'h07, 8'h00, 8'hA5};
   logic       v_par[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic       v_ack[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .send_data(send_data), .send_valid(send_valid),
      .busy(busy), .done(done), .error(error),
      .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
      .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe), .dbg_state(dbg_state)
   );

   // clock/reset block
   always #10 clock = ~clock;
   always @(posedge clock) cyc++;

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // response monitor and inhibit-length monitor
   always @(negedge clock) begin
      if (reset) begin
         inh_cnt     = 0;
         prev_clk_oe = 1'b0;
      end else begin
         if (prev_clk_oe && !clk_oe) rel_cyc = cyc;
         if (clk_oe && !dat_oe) begin
            inh_cnt++;
         end else begin
            if (clk_oe && dat_oe && inh_cnt != 0) chk("inhibit_len", inh_cnt, INH);
            inh_cnt = 0;
         end
         if (done || error) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", {30'd0, done, error}, 0);
            end else begin
               e_resp = exp_q.pop_front();
               chk("resp_done", done, e_resp[1]);
               chk("resp_error", error, e_resp[0]);
               chk("resp_busy", busy, 0);
               chk("resp_lines", {clk_oe, dat_oe}, 0);
               if (e_resp[2]) chk("timeout_latency", cyc - rel_cyc, TMO);
            end
            done_cyc = cyc;
         end
         prev_clk_oe = clk_oe;
      end
   end

   // driver tasks
   task automatic send_one(input logic [7:0] d);
      @(negedge clock);
      send_data  = d;
      send_valid = 1'b1;
      @(negedge clock);
      send_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (exp_q.size() != 0 && t < LIM) begin
         @(negedge clock);
         t++;
      end
      chk("resp_wait", t < LIM, 1);
   endtask

   task automatic wait_release(output int t);
      t = 0;
      while (!clk_oe && t < LIM) begin
         @(negedge clock);
         t++;
      end
      while (clk_oe && t < LIM) begin
         @(negedge clock);
         t++;
      end
   endtask

   // keyboard model: clocks n_edges falling edges, samples each bit before the rising edge
   task automatic dev_run(input int n_edges, input logic ack, input logic check);
      int t;
      logic [10:0] got;
      logic [10:0] e;
      wait_release(t);
      chk("dev_rts_wait", t < LIM, 1);
      if (t >= LIM) return;
      got = '0;
      repeat (5) @(negedge clock);
      got[0] = ps2_dat_line;
      for (int n = 1; n <= n_edges; n++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clock);
         if (n <= 10) got[n] = ps2_dat_line;
         dev_clk_low = 1'b0;
         if (n == 10 && ack) begin
            repeat (HALF / 2) @(negedge clock);
            dev_dat_low = 1'b1;
            repeat (HALF / 2) @(negedge clock);
         end else begin
            repeat (HALF) @(negedge clock);
         end
      end
      dev_dat_low = 1'b0;
      if (check) begin
         if (frame_q.size() == 0) begin
            chk("frame_unexpected", 1, 0);
         end else begin
            e = frame_q.pop_front();
            chk("frame", got, e);
         end
      end
   endtask

   initial begin
      int t;
      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_clk_oe", clk_oe, 0);
      chk("rst_dat_oe", dat_oe, 0);
      chk("rst_state", dbg_state, 0);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // directed frames: 0xED, 0x07, 0x00 with ACK, 0xA5 with NACK
      for (int i = 0; i < 4; i++) begin
         frame_q.push_back({1'b1, v_par[i], v_data[i], 1'b0});
         exp_q.push_back({1'b0, v_ack[i], ~v_ack[i]});
         send_one(v_data[i]);
         dev_run(11, v_ack[i], 1'b1);
         wait_idle();
         repeat (10) @(negedge clock);
      end

      // device never clocks after request-to-send
      exp_q.push_back(3'b101);
      send_one(8'h3C);
      wait_idle();
      chk("tmo_lines", {clk_oe, dat_oe}, 0);
      repeat (10) @(negedge clock);

      // send_valid held high, data changed mid-frame
      frame_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
      exp_q.push_back(3'b010);
      @(negedge clock);
      send_data  = 8'hFF;
      send_valid = 1'b1;
      fork
         dev_run(11, 1'b1, 1'b1);
         begin
            int t2;
            wait_release(t2);
            repeat (100) @(negedge clock);
            send_data = 8'h55;
         end
      join
      wait_idle();
      t = 0;
      while (!busy && t < LIM) begin
         @(negedge clock);
         t++;
      end
      chk("reaccept_delay", cyc - done_cyc, 2);
      send_valid = 1'b0;
      frame_q.push_back({1'b1, 1'b1, 8'h55, 1'b0});
      exp_q.push_back(3'b010);
      dev_run(11, 1'b1, 1'b1);
      wait_idle();
      repeat (10) @(negedge clock);

      // reset during bit 4
      send_one(8'h81);
      dev_run(4, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("midrst_clk_oe", clk_oe, 0);
      chk("midrst_dat_oe", dat_oe, 0);
      chk("midrst_busy", busy, 0);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (50) @(negedge clock);
      frame_q.push_back({1'b1, 1'b1, 8'h5A, 1'b0});
      exp_q.push_back(3'b010);
      send_one(8'h5A);
      dev_run(11, 1'b1, 1'b1);
      wait_idle();
      repeat (20) @(negedge clock);

      // final report
      chk("resp_q_empty", exp_q.size(), 0);
      chk("frame_q_empty", frame_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
